// File: rtl/jtdsp16_sout_if.sv
// jtdsp16_sout_if: word FIFO write bus of the jtdsp16_sout serializer.
//   wr    - write strobe, one word per clk cycle while high
//   din   - write data (DW bits)
//   full  - FIFO holds DEPTH words
//   empty - FIFO holds no words
// master: word producer. slave: the serializer.
interface jtdsp16_sout_if #(
    parameter int DW = 16
);
    logic          wr;
    logic [DW-1:0] din;
    logic          full;
    logic          empty;

    modport master (output wr, din, input full, empty);
    modport slave  (input wr, din, output full, empty);
endinterface

// File: rtl/jtdsp16_sout.sv
// jtdsp16_sout: framed serial word output with a shared word FIFO.
// Words written on the bus are shifted out on sdo, CKDIV cen ticks per bit,
// CH channels per frame, with no gaps between words or frames.
//   clk, rst_n - clock, asynchronous active-low reset
//   cen        - clock enable for everything except FIFO writes
//   en         - run request; dropping it finishes the current frame
//   lsb_first  - bit order, sampled at each word load
//   uflow_clr  - clears the sticky uflow/oflow flags
//   bus        - FIFO write side (wr, din, full, empty)
//   ock, sdo   - serial bit clock and data
//   old        - word-load strobe, one cen tick long
//   chan       - channel index of the word being shifted
//   uflow      - sticky: a word slot started with the FIFO empty
//   oflow      - sticky: a write was dropped because the FIFO was full
module jtdsp16_sout #(
    parameter int DW    = 16,
    parameter int CH    = 2,
    parameter int DEPTH = 4,
    parameter int CKDIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 en,
    input  logic                 lsb_first,
    input  logic                 uflow_clr,
    jtdsp16_sout_if.slave        bus,
    output logic                 ock,
    output logic                 sdo,
    output logic                 old,
    output logic [2:0]           chan,
    output logic                 uflow,
    output logic                 oflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CKDIV);
    localparam int BW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic [TW-1:0] tcnt, tnext;
    logic [BW-1:0] bcnt;
    logic [DW-1:0] sreg, shifted, word_in;
    logic          lsb;
    logic          fifo_full, fifo_empty;
    logic          tick_end, word_end, frame_end;
    logic          load, pop, push;

    always_comb begin
        fifo_full  = cnt == (AW+1)'(DEPTH);
        fifo_empty = cnt == '0;
        tick_end   = tcnt == TW'(CKDIV-1);
        word_end   = tick_end && (bcnt == BW'(DW-1));
        frame_end  = chan == 3'(CH-1);
        // A word slot starts on the IDLE->RUN tick and on every word boundary,
        // except the last boundary of a frame when en is low.
        load = 1'b0;
        if (cen) begin
            if (state == IDLE) load = en;
            else               load = word_end && !(frame_end && !en);
        end
        pop     = load && !fifo_empty;
        // A full FIFO still takes a write when a pop frees a slot this cycle.
        push    = bus.wr && (!fifo_full || pop);
        word_in = fifo_empty ? '0 : mem[rptr];
        shifted = lsb ? (sreg >> 1) : (sreg << 1);
        tnext   = tick_end ? '0 : tcnt + 1'b1;
    end

    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            uflow <= 1'b0;
            oflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            // Set events take priority over the clear.
            if (load && fifo_empty)             uflow <= 1'b1;
            else if (uflow_clr)                 uflow <= 1'b0;
            if (bus.wr && fifo_full && !pop)    oflow <= 1'b1;
            else if (uflow_clr)                 oflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            sreg  <= '0;
            lsb   <= 1'b0;
            ock   <= 1'b0;
            sdo   <= 1'b0;
            old   <= 1'b0;
            chan  <= '0;
        end else if (cen) begin
            old <= load;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        tcnt  <= '0;
                        bcnt  <= '0;
                        chan  <= '0;
                        lsb   <= lsb_first;
                        sreg  <= word_in;
                        sdo   <= lsb_first ? word_in[0] : word_in[DW-1];
                        ock   <= 1'b1;
                    end
                end
                default: begin
                    // STOP only differs from RUN by ending at the frame boundary.
                    state <= en ? RUN : STOP;
                    if (word_end && frame_end && !en) begin
                        state <= IDLE;
                        tcnt  <= '0;
                        bcnt  <= '0;
                        chan  <= '0;
                        sreg  <= '0;
                        ock   <= 1'b0;
                        sdo   <= 1'b0;
                    end else begin
                        tcnt <= tnext;
                        ock  <= tnext < TW'(CKDIV/2);
                        if (word_end) begin
                            bcnt <= '0;
                            chan <= frame_end ? 3'd0 : chan + 3'd1;
                            lsb  <= lsb_first;
                            sreg <= word_in;
                            sdo  <= lsb_first ? word_in[0] : word_in[DW-1];
                        end else if (tick_end) begin
                            bcnt <= bcnt + 1'b1;
                            sreg <= shifted;
                            sdo  <= lsb ? shifted[0] : shifted[DW-1];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtdsp16_sout.sv
// tb_jtdsp16_sout: directed and randomized bench for jtdsp16_sout.
// A reference model tracks the run state as a tick index within the current
// word and derives bit, ock, old and sdo from it arithmetically.
module tb_jtdsp16_sout;
    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int CKDIV = 4;
    localparam int WT    = DW * CKDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0, en = 1'b0, lsb_first = 1'b0, uflow_clr = 1'b0;
    logic       ock, sdo, old, uflow, oflow;
    logic [2:0] chan;

    jtdsp16_sout_if #(.DW(DW)) bus ();

    jtdsp16_sout #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .CKDIV(CKDIV)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .en(en), .lsb_first(lsb_first),
        .uflow_clr(uflow_clr), .bus(bus), .ock(ock), .sdo(sdo), .old(old),
        .chan(chan), .uflow(uflow), .oflow(oflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] q[$];
    bit            m_act, m_lsb, m_uflow, m_oflow;
    int            m_t, m_chan;
    logic [DW-1:0] m_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_act = 0; m_lsb = 0; m_uflow = 0; m_oflow = 0;
        m_t = 0; m_chan = 0; m_word = '0;
    endtask

    task automatic model_step(input logic c, input logic e, input logic w, input logic l,
                              input logic k, input logic [DW-1:0] d);
        bit popd, uset, oset, ld;
        popd = 0; uset = 0; oset = 0; ld = 0;
        if (c) begin
            if (!m_act) begin
                if (e) begin m_act = 1; m_t = 0; m_chan = 0; ld = 1; end
            end else begin
                m_t++;
                if (m_t == WT) begin
                    m_t = 0;
                    if (m_chan == CH-1 && !e) m_act = 0;
                    else begin m_chan = (m_chan + 1) % CH; ld = 1; end
                end
            end
            if (ld) begin
                m_lsb = l;
                if (q.size() > 0) begin m_word = q.pop_front(); popd = 1; end
                else begin m_word = '0; uset = 1; end
            end
        end
        if (w) begin
            if (q.size() < DEPTH) q.push_back(d);
            else oset = 1;
        end
        m_uflow = uset ? 1'b1 : (k ? 1'b0 : m_uflow);
        m_oflow = oset ? 1'b1 : (k ? 1'b0 : m_oflow);
    endtask

    function automatic logic [9:0] exp_out();
        logic       o_ock, o_sdo, o_old;
        logic [2:0] ch;
        int         b;
        o_ock = 0; o_sdo = 0; o_old = 0; ch = '0;
        if (m_act) begin
            b     = m_t / CKDIV;
            o_ock = (m_t % CKDIV) < CKDIV/2;
            o_sdo = m_lsb ? m_word[b] : m_word[DW-1-b];
            o_old = (m_t == 0);
            ch    = 3'(m_chan);
        end
        return {q.size() == DEPTH, q.size() == 0, o_ock, o_sdo, o_old, ch, m_uflow, m_oflow};
    endfunction

    function automatic logic [9:0] obs_out();
        return {bus.full, bus.empty, ock, sdo, old, chan, uflow, oflow};
    endfunction

    // One clk cycle with the current inputs, then compare against the model.
    task automatic cyc();
        logic c, e, w, l, k;
        logic [DW-1:0] d;
        c = cen; e = en; w = bus.wr; l = lsb_first; k = uflow_clr; d = bus.din;
        @(posedge clk);
        #1;
        model_step(c, e, w, l, k, d);
        chk("cycle", 32'(obs_out()), 32'(exp_out()));
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bus.wr = 1'b1; bus.din = d;
        cyc();
        bus.wr = 1'b0;
    endtask

    logic [15:0] rec;
    int          nhi;

    initial begin
        bus.wr = 1'b0; bus.din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs_out()), 'h100);
        rst_n = 1'b1;
        cen = 1'b1;
        repeat (3) cyc();

        // Two words, MSB first, en pulsed for one tick: a single frame.
        write_word(16'hA5C3);
        write_word(16'h0F0F);
        rec = '0;
        for (int i = 0; i < 140; i++) begin
            en = (i == 0);
            cyc();
            if (i < 64 && i % 4 == 0) rec[15 - i/4] = sdo;
            if (i == 0)  chk("old_t0", 32'(old), 1);
            if (i == 2)  chk("ock_t2", 32'(ock), 0);
            if (i == 4)  chk("ock_t4", 32'(ock), 1);
            if (i == 63) chk("chan_t63", 32'(chan), 0);
            if (i == 64) begin
                chk("old_t64", 32'(old), 1);
                chk("chan_t64", 32'(chan), 1);
                chk("empty_pop2", 32'(bus.empty), 1);
            end
        end
        chk("word0_msb", 32'(rec), 'hA5C3);
        chk("idle_ock", 32'(ock), 0);

        // LSB first, 16'h0001: sdo high for the first bit only.
        lsb_first = 1'b1;
        write_word(16'h0001);
        nhi = 0;
        for (int i = 0; i < 140; i++) begin
            en = (i == 0);
            cyc();
            if (i < 64 && sdo) nhi++;
            if (i == 3) chk("lsb_t3", 32'(sdo), 1);
            if (i == 4) chk("lsb_t4", 32'(sdo), 0);
        end
        chk("lsb_hi_ticks", 32'(nhi), 4);
        lsb_first = 1'b0;
        uflow_clr = 1'b1; cyc(); uflow_clr = 1'b0;

        // Empty FIFO: a zero word and a sticky underflow.
        nhi = 0;
        for (int i = 0; i < 140; i++) begin
            en = (i == 0);
            cyc();
            if (i < 64 && sdo) nhi++;
        end
        chk("uflow_zero_ticks", 32'(nhi), 0);
        chk("uflow_set", 32'(uflow), 1);
        uflow_clr = 1'b1; cyc(); uflow_clr = 1'b0;
        chk("uflow_clr", 32'(uflow), 0);

        // Overflow: five writes into a depth-4 FIFO, then a write during a pop.
        for (int k = 0; k < 5; k++) begin
            write_word(16'(16'h1111 * (k + 1)));
            if (k == 3) chk("full_4th", 32'(bus.full), 1);
        end
        chk("oflow_5th", 32'(oflow), 1);
        bus.wr = 1'b1; bus.din = 16'hBEEF; en = 1'b1;
        cyc();
        bus.wr = 1'b0; en = 1'b0;
        chk("full_wr_pop", 32'(bus.full), 1);
        for (int i = 1; i < 140; i++) cyc();
        uflow_clr = 1'b1; cyc(); uflow_clr = 1'b0;
        chk("oflow_clr", 32'(oflow), 0);

        // en dropped in channel 0, re-raised in channel 1: frames run back to back.
        write_word(16'h5AA5);
        for (int i = 0; i < 300; i++) begin
            en = (i == 0) || (i >= 80 && i <= 140);
            cyc();
            if (i == 128) begin
                chk("frame2_old", 32'(old), 1);
                chk("frame2_chan", 32'(chan), 0);
            end
            if (i == 260) chk("stop_idle_ock", 32'(ock), 0);
        end

        // Reset in the middle of a word.
        write_word(16'h1234);
        write_word(16'h5678);
        en = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_word", 32'(obs_out()), 'h100);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("rst_no_pop", 32'(bus.empty), 1);

        // Randomized traffic with a sparse clock enable.
        for (int i = 0; i < 3000; i++) begin
            cen       = ($urandom % 4) != 0;
            if ($urandom % 64 == 0) en = ~en;
            bus.wr    = ($urandom % 4) == 0;
            bus.din   = DW'($urandom);
            lsb_first = 1'($urandom % 2);
            uflow_clr = ($urandom % 32) == 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtdsp16_sout.md
JTDSP16_SOUT -- requirements
Module: jtdsp16_sout

Interface
REQ-001 Parameter DW, default 16: serial word width in bits, 8..32.
REQ-002 Parameter CH, default 2: channels per frame, 1..8.
REQ-003 Parameter DEPTH, default 4: shared word FIFO depth, a power of 2, at least 2.
REQ-004 Parameter CKDIV, default 4: cen ticks per serial bit, even, at least 2.
REQ-005 Port clk, input, 1 bit: sole clock; one clock.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port cen, input, 1 bit: clock enable; all state except FIFO writes advances only when cen=1.
REQ-008 Port en, input, 1 bit: serializer run request.
REQ-009 Port lsb_first, input, 1 bit: 0 = MSB first, 1 = LSB first; sampled at each word load.
REQ-010 Port wr, input, 1 bit: FIFO write strobe, one word per clk cycle with wr=1, independent of cen.
REQ-011 Port din, input, DW bits: FIFO write data.
REQ-012 Port uflow_clr, input, 1 bit: clears both sticky error flags.
REQ-013 Port full, output, 1 bit: FIFO holds DEPTH words.
REQ-014 Port empty, output, 1 bit: FIFO holds 0 words.
REQ-015 Port ock, output, 1 bit: serial bit clock.
REQ-016 Port sdo, output, 1 bit: serial data.
REQ-017 Port old, output, 1 bit: word-load strobe.
REQ-018 Port chan, output, 3 bits: channel index of the word being shifted.
REQ-019 Port uflow, output, 1 bit: sticky underflow flag.
REQ-020 Port oflow, output, 1 bit: sticky overflow flag.

Function
REQ-021 FSM states SHALL be IDLE, RUN and STOP; reset state is IDLE.
REQ-022 IDLE: ock=0, sdo=0, old=0, chan=0; on a cen tick with en=1, go to RUN; that tick is tick 0 of the channel-0 word.
REQ-023 A word period SHALL be exactly DW*CKDIV cen ticks; bit b occupies ticks b*CKDIV .. b*CKDIV+CKDIV-1.
REQ-024 ock SHALL be 1 for the first CKDIV/2 ticks of each bit and 0 for the rest; sdo changes only at bit boundaries.
REQ-025 At tick 0 of every word: pop the FIFO head into the shift register; old=1 for that cen tick only; chan = word's channel; sdo = bit DW-1 (lsb_first=0) or bit 0 (lsb_first=1) in the same tick.
REQ-026 If the FIFO is empty at tick 0: shift all zeros, no pop, set uflow.
REQ-027 chan SHALL count 0..CH-1 and wrap to 0 after channel CH-1; there are no gap ticks between words or frames.
REQ-028 en=0 sampled during RUN: go to STOP; the current frame completes through channel CH-1, then go to IDLE.
REQ-029 en=1 during STOP: return to RUN; the frame continues uninterrupted.
REQ-030 FIFO write with wr=1 and full=0: accept din.
REQ-031 FIFO write with wr=1 and full=1: accept only if a pop occurs in the same clk cycle; otherwise drop the word and set oflow.
REQ-032 Write and pop in the same cycle while empty=0: occupancy unchanged.
REQ-033 The popped word SHALL be the oldest word (FIFO order); pointers wrap modulo DEPTH.
REQ-034 full and empty SHALL reflect occupancy registered at the clk edge.
REQ-035 uflow_clr=1: clear both sticky flags; a set event in the same cycle wins over the clear.

Reset
REQ-036 rst_n=0 SHALL asynchronously force the following: state=IDLE, FIFO empty (empty=1, full=0), ock=0, sdo=0, old=0, chan=0, uflow=0, oflow=0, bit/tick counters=0.
REQ-037 Reset asserted mid-word SHALL abort the word with no further pops; after release, operation resumes only via the IDLE to RUN transition.

Verification
REQ-038 Defaults, cen=1 always: write 16'hA5C3 and 16'h0F0F, then en=1. Required: old pulses at ticks 0 and 64; sdo carries A5C3 MSB-first with ock period 4 ticks; chan goes 0 then 1; empty=1 after the second pop.
REQ-039 lsb_first=1, one word 16'h0001. Required: sdo=1 only during ticks 0..3.
REQ-040 en=1 with the FIFO empty. Required: sdo=0 for the whole word, uflow=1; after uflow_clr, uflow=0.
REQ-041 Write 5 words with no pop. Required: full=1 after the 4th word; the 5th word is dropped and oflow=1. Then write while full during a pop tick. Required: accepted, full stays 1.
REQ-042 en dropped during channel 0. Required: channel 1 is still sent, then IDLE with ock=0. en re-raised during channel 1. Required: continuous next frame.
REQ-043 rst_n pulsed low mid-word. Required: all outputs return immediately to reset values and the FIFO is empty.
